master_slave_link: RTL and testbench

- Self-contained valid/ready streaming pair: a traffic-generating master and a checking slave joined by an 8-bit handshake channel, `vaild`/`ready`/`master_data`.
- The master emits an incrementing byte sequence. The slave applies a periodic back-pressure pattern, captures every accepted byte and checks sequence continuity.
- Used as a protocol reference/loopback block and as a bring-up target for handshake checkers.

---
 rtl/hs_link_pkg.sv | 13 +
 rtl/hs_master.sv | 79 +++++++
 rtl/hs_slave.sv | 77 +++++++
 rtl/master_slave_link.sv | 54 +++++
 tb/tb_master_slave_link.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/hs_link_pkg.sv
// Shared types and constants for the master/slave handshake link.
package hs_link_pkg;

   localparam int unsigned DataWDefault = 8;
   localparam int unsigned CntW         = 16;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StGap
   } master_state_e;

endpackage

// File: rtl/hs_master.sv
// Traffic master: emits an incrementing byte stream on a valid/ready channel and
// drops valid for one cycle after every GapEvery accepted beats.
module hs_master
   import hs_link_pkg::*;
#(
   parameter int unsigned DataW    = DataWDefault,
   parameter int unsigned GapEvery = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [DataW-1:0] data_o
);

   // Beat counter only needs to reach GapEvery-1; keep at least one bit.
   localparam int unsigned BeatW    = (GapEvery > 1) ? $clog2(GapEvery) : 1;
   localparam int unsigned LastBeat = (GapEvery > 0) ? GapEvery - 1 : 0;

   master_state_e    state_q, state_d;
   logic             valid_q, valid_d;
   logic [DataW-1:0] data_q, data_d;
   logic [BeatW-1:0] beat_q, beat_d;
   logic             accept;

   // Next-state: sequence advance on acceptance, one-cycle gap on the last beat of a group.
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      data_d  = data_q;
      beat_d  = beat_q;
      accept  = valid_q && ready_i;
      case (state_q)
         StIdle: begin
            state_d = StSend;
            valid_d = 1'b1;
         end
         StSend: begin
            if (accept) begin
               data_d = data_q + 1'b1;
               if ((GapEvery != 0) && (beat_q == BeatW'(LastBeat))) begin
                  beat_d  = '0;
                  state_d = StGap;
                  valid_d = 1'b0;
               end else if (GapEvery != 0) begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         StGap: begin
            state_d = StSend;
            valid_d = 1'b1;
         end
         default: begin
            state_d = StIdle;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         valid_q <= 1'b0;
         data_q  <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         beat_q  <= beat_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/hs_slave.sv
// Checking slave: periodic back-pressure, capture of accepted bytes and a sticky
// sequence-continuity check that resynchronises after each beat.
module hs_slave
   import hs_link_pkg::*;
#(
   parameter int unsigned DataW       = DataWDefault,
   parameter int unsigned ReadyPeriod = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   input  logic [DataW-1:0] data_i,
   output logic             ready_o,
   output logic [DataW-1:0] data_o,
   output logic             strobe_o,
   output logic [CntW-1:0]  count_o,
   output logic             err_o
);

   localparam int unsigned PhW = $clog2(ReadyPeriod);

   logic [PhW-1:0]   phase_q, phase_d;
   logic             ready_q, ready_d;
   logic [DataW-1:0] data_q, data_d;
   logic             strobe_q, strobe_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             err_q, err_d;
   logic [DataW-1:0] exp_q, exp_d;
   logic             accept;

   // Next-state: ready is low in the cycle after the phase counter wraps to zero.
   always_comb begin
      accept   = valid_i && ready_q;
      phase_d  = (phase_q == PhW'(ReadyPeriod - 1)) ? '0 : phase_q + 1'b1;
      ready_d  = (phase_d != '0);
      data_d   = data_q;
      strobe_d = accept;
      count_d  = count_q;
      err_d    = err_q;
      exp_d    = exp_q;
      if (accept) begin
         data_d  = data_i;
         count_d = count_q + 1'b1;
         err_d   = err_q | (data_i != exp_q);
         // Resync to the received byte so a single error does not cascade.
         exp_d   = data_i + 1'b1;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q  <= '0;
         ready_q  <= 1'b0;
         data_q   <= '0;
         strobe_q <= 1'b0;
         count_q  <= '0;
         err_q    <= 1'b0;
         exp_q    <= '0;
      end else begin
         phase_q  <= phase_d;
         ready_q  <= ready_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
         count_q  <= count_d;
         err_q    <= err_d;
         exp_q    <= exp_d;
      end
   end

   assign ready_o  = ready_q;
   assign data_o   = data_q;
   assign strobe_o = strobe_q;
   assign count_o  = count_q;
   assign err_o    = err_q;

endmodule

// File: rtl/master_slave_link.sv
// Loopback pair: traffic master wired to a checking slave, channel exported for observation.
module master_slave_link
   import hs_link_pkg::*;
#(
   parameter int unsigned DATA_W       = DataWDefault,
   parameter int unsigned READY_PERIOD = 4,
   parameter int unsigned GAP_EVERY    = 8
) (
   input  logic              sys_clk,
   input  logic              reset,
   output logic              vaild,
   output logic              ready,
   output logic [DATA_W-1:0] master_data,
   output logic [DATA_W-1:0] slave_data,
   output logic              rx_strobe,
   output logic [CntW-1:0]   rx_count,
   output logic              seq_err
);

   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              s_ready;

   hs_master #(
      .DataW    (DATA_W),
      .GapEvery (GAP_EVERY)
   ) u_master (
      .clk_i   (sys_clk),
      .rst_ni  (reset),
      .ready_i (s_ready),
      .valid_o (m_valid),
      .data_o  (m_data)
   );

   hs_slave #(
      .DataW       (DATA_W),
      .ReadyPeriod (READY_PERIOD)
   ) u_slave (
      .clk_i    (sys_clk),
      .rst_ni   (reset),
      .valid_i  (m_valid),
      .data_i   (m_data),
      .ready_o  (s_ready),
      .data_o   (slave_data),
      .strobe_o (rx_strobe),
      .count_o  (rx_count),
      .err_o    (seq_err)
   );

   assign vaild       = m_valid;
   assign ready       = s_ready;
   assign master_data = m_data;

endmodule

// File: tb/tb_master_slave_link.sv
// Scoreboard bench for master_slave_link: accepted beats push expected captures into a
// queue, a monitor pops and compares whenever rx_strobe is seen.
module tb_master_slave_link;

   logic        sys_clk = 1'b0;
   logic        reset   = 1'b0;
   logic        vaild, ready, rx_strobe, seq_err;
   logic [7:0]  master_data, slave_data;
   logic [15:0] rx_count;
   logic        vaild2, ready2, rx_strobe2, seq_err2;
   logic [7:0]  master_data2, slave_data2;
   logic [15:0] rx_count2;

   int checks = 0;
   int errors = 0;

   master_slave_link dut (
      .sys_clk     (sys_clk),
      .reset       (reset),
      .vaild       (vaild),
      .ready       (ready),
      .master_data (master_data),
      .slave_data  (slave_data),
      .rx_strobe   (rx_strobe),
      .rx_count    (rx_count),
      .seq_err     (seq_err)
   );

   master_slave_link #(
      .DATA_W       (8),
      .READY_PERIOD (4),
      .GAP_EVERY    (0)
   ) dut2 (
      .sys_clk     (sys_clk),
      .reset       (reset),
      .vaild       (vaild2),
      .ready       (ready2),
      .master_data (master_data2),
      .slave_data  (slave_data2),
      .rx_strobe   (rx_strobe2),
      .rx_count    (rx_count2),
      .seq_err     (seq_err2)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Edge index since reset release.
   int k = 0;
   always @(posedge sys_clk or negedge reset) begin
      if (!reset) k <= 0;
      else        k <= k + 1;
   end

   typedef struct {
      logic [7:0]  d;
      logic [15:0] c;
   } exp_t;
   exp_t sb[$];

   logic       mon_en = 1'b1;
   logic [7:0] exp_seq, prev_md;
   int         cnt, since_gap, n_acc, gaps2;
   logic       gap_now, pend, hold_prev, last255, seen_wrap;
   int         acc_k[7];
   int         exp_k[7] = '{1, 2, 3, 5, 6, 7, 9};

   // Monitor: compares channel and capture outputs against the bench model each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge sys_clk);
         if (!reset) begin
            if (mon_en)
               check("rst_zero", {vaild, ready, master_data, slave_data, rx_strobe, rx_count,
                                  seq_err}, 64'd0);
            exp_seq = 8'd0; cnt = 0; since_gap = 0; n_acc = 0; gaps2 = 0;
            gap_now = 1'b0; pend = 1'b0; hold_prev = 1'b0; last255 = 1'b0; seen_wrap = 1'b0;
            prev_md = 8'd0;
            sb.delete();
         end else if (mon_en && k >= 1) begin
            check("ready_pat", ready, ((k % 4) != 0));
            check("vaild", vaild, !gap_now);
            check("master_data", master_data, exp_seq);
            if (hold_prev) check("hold_data", master_data, prev_md);
            check("rx_strobe", rx_strobe, pend);
            if (pend) begin
               if (sb.size() == 0) begin
                  check("sb_empty", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("slave_data", slave_data, e.d);
                  check("rx_count", rx_count, e.c);
               end
            end
            check("seq_err", seq_err, 0);
            if (!vaild2 && rx_count2 < 16'd100) gaps2++;
            pend      = vaild && ready;
            hold_prev = vaild && !ready;
            prev_md   = master_data;
            gap_now   = 1'b0;
            if (pend) begin
               if (n_acc < 7) acc_k[n_acc] = k;
               n_acc++;
               if (last255 && master_data == 8'd0) seen_wrap = 1'b1;
               last255 = (master_data == 8'hff);
               cnt++;
               sb.push_back('{exp_seq, 16'(cnt)});
               exp_seq = exp_seq + 8'd1;
               since_gap++;
               if (since_gap == 8) begin
                  since_gap = 0;
                  gap_now   = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      int  n;
      logic ok;

      // Reset held for 10 cycles; monitor checks all-zero outputs.
      repeat (10) @(negedge sys_clk);
      #1 reset = 1'b1;

      // Mid-stream reset once five beats have been captured.
      n = 0;
      while (rx_count != 16'd5 && n < 100) begin @(negedge sys_clk); n++; end
      check("wait_rx5", (n < 100), 1);
      #2 reset = 1'b0;
      #1 check("async_rst", {vaild, ready, master_data, slave_data, rx_strobe, rx_count,
                             seq_err}, 64'd0);
      repeat (3) @(negedge sys_clk);
      #1 reset = 1'b1;

      // First capture after release is byte 0, count 1.
      n = 0;
      while (!rx_strobe && n < 50) begin @(negedge sys_clk); n++; end
      check("first_data", slave_data, 8'd0);
      check("first_count", rx_count, 16'd1);

      // Acceptance cycles of the first seven beats.
      n = 0;
      while (cnt < 10 && n < 100) begin @(posedge sys_clk); n++; end
      for (int i = 0; i < 7; i++) check($sformatf("acc_edge%0d", i), acc_k[i], exp_k[i]);

      // Long run through the 8-bit wrap.
      n = 0;
      while (cnt < 300 && n < 3000) begin @(posedge sys_clk); n++; end
      check("wait_300", (n < 3000), 1);
      @(negedge sys_clk);
      check("rx300", rx_count, 16'd300);
      check("seq_err_300", seq_err, 0);
      check("wrap_seen", seen_wrap, 1);
      check("nogap_beats", (rx_count2 >= 16'd100), 1);
      check("nogap_count", gaps2, 0);

      // Error injection on a fresh stream.
      mon_en = 1'b0;
      reset  = 1'b0;
      repeat (2) @(negedge sys_clk);
      #1 reset = 1'b1;
      n = 0;
      ok = 1'b0;
      while (!ok && n < 200) begin
         @(negedge sys_clk);
         ok = vaild && ready && (master_data == 8'h10);
         n++;
      end
      check("wait_10", ok, 1);
      check("err_clear", seq_err, 0);
      force dut.m_data = 8'h55;
      @(negedge sys_clk);
      check("err_set", seq_err, 1);
      check("err_capture", slave_data, 8'h55);
      release dut.m_data;
      n = 0;
      ok = 1'b0;
      while (!ok && n < 20) begin
         @(negedge sys_clk);
         ok = vaild && ready;
         n++;
      end
      check("wait_beat", ok, 1);
      force dut.m_data = 8'h56;
      @(negedge sys_clk);
      check("err_follow", seq_err, 1);
      check("follow_capture", slave_data, 8'h56);
      release dut.m_data;
      for (int i = 0; i < 5; i++) begin
         @(negedge sys_clk);
         check("err_sticky", seq_err, 1);
      end
      #2 reset = 1'b0;
      #1 check("err_rst", seq_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
